map_ram_arbiter: RTL and testbench
==================================

# map_ram_arbiter

Time-slot arbiter and clear sequencer for the single-port 4096×4 map RAM (`new_ram`) shared by the VGA scan-out and the snake game logic. A fixed 4-cycle slot wheel reserves one slot for the VGA pixel fetch, giving it guaranteed bandwidth at 25 MHz pixel rate. The remaining three slots go to a req/ack game port. A clear engine fills the whole map with one cell code on request, for example on game restart.

## Interface
Parameters:
- ADDR_W, 12, map address width
- DATA_W, 4, cell code width
- SLOT_N, 4, cycles per slot wheel period; slot 0 is the VGA slot

Ports:
- clk_100mhz  in  1  system clock; all logic on rising edge
- RSTN  in  1  reset, synchronous and active-low
- vga_addr  in  ADDR_W  pixel cell address from the VGA timing block
- vga_data  out  DATA_W  cell code for vga_addr, registered
- g_req  in  1  game access request; held with g_we/g_addr/g_wdata stable until g_ack
- g_we  in  1  1 = write, 0 = read
- g_addr  in  ADDR_W  game access address
- g_wdata  in  DATA_W  game write data
- g_ack  out  1  combinational; high in the cycle the access is issued to RAM
- g_rdata  out  DATA_W  read result, registered
- g_rvalid  out  1  one-cycle pulse qualifying g_rdata
- clr_start  in  1  start full-map clear; one-cycle pulse
- clr_value  in  DATA_W  fill code, sampled with clr_start
- clr_busy  out  1  high while the clear is in progress
- ram_addr  out  ADDR_W  to RAM address
- ram_we  out  1  to RAM write enable
- ram_wdata  out  DATA_W  to RAM data_in
- ram_rdata  in  DATA_W  from RAM data_out; synchronous read, valid the cycle after the address

## Operation
- slot: mod-SLOT_N counter, free-running out of reset.
- Slot 0 (VGA): ram_addr=vga_addr, ram_we=0.
  - In the following cycle (slot 1), ram_rdata is loaded into vga_data.
  - vga_data is updated once per period and held otherwise.
- Slots 1..SLOT_N-1, state ST_IDLE:
  - If g_req: ram_addr=g_addr, ram_we=g_we, ram_wdata=g_wdata, and g_ack=1.
  - Otherwise ram_we=0 and the RAM is idle.
- Game read: ram_rdata is captured into g_rdata at the end of the cycle after ack. g_rvalid pulses in the next cycle (2 cycles after ack).
- Game writes produce no rvalid.
- Back-to-back acks are allowed: up to SLOT_N-1 per period. g_ack is never high in slot 0.
- FSM ST_IDLE → ST_CLEAR on clr_start while in ST_IDLE:
  - clr_value is latched and clr_ptr is set to 0.
  - In ST_CLEAR, every non-VGA slot writes the latched value at clr_ptr, then clr_ptr increments.
  - After the write to address 2^ADDR_W−1, the FSM returns to ST_IDLE.
- During ST_CLEAR: VGA slots are still served, g_ack=0 (g_req stays pending), and clr_start is ignored.
- clr_start arriving in the same cycle as an ack-able g_req: the ack wins that cycle. The clear begins next cycle, and the FSM transition still happens.
- clr_busy = (state == ST_CLEAR).

## Timing
- Reset (RSTN low at an edge): slot=0, state=ST_IDLE, clr_ptr=0, vga_data=0, g_rdata=0, g_rvalid=0.
- While RSTN is low, combinational outputs are forced to g_ack=0 and ram_we=0.
- Reset mid-clear aborts the clear. Already-written cells stay written.
- Reset between a read ack and rvalid cancels the rvalid.
- VGA latency: vga_data reflects the vga_addr sampled in slot 0 from the slot 1 edge onward, i.e. at most 2 cycles after sampling and stable for SLOT_N cycles.
- Worst-case game wait when idle: 1 cycle (slot 0).
- Clear duration: ceil(4096/3) periods. The last write lands in cycle 5461 after entry, counting from the entry cycle as slot 0.
- clr_ptr wraps only via the terminal-count exit, never by silent overflow.

## Structure
- Package `map_ram_pkg` holds:
  - ADDR_W, DATA_W, SLOT_N, MAP_DEPTH=4096, VGA_SLOT=0
  - the state enum {ST_IDLE, ST_CLEAR}
  - cell codes shared with the game and VGA blocks (EMPTY=4'h0 etc.)
- One sub-module, `map_clear_engine`: clr_ptr, the latched value, a done flag, and an advance input driven by non-VGA slots in ST_CLEAR.
- The arbiter top holds the slot counter, the RAM mux, and the capture registers.

## Test plan
- Reset then release, RAM preloaded with addr[3:0] at each cell. Hold vga_addr=12'h123 → vga_data=4'h3 from the first slot 1 edge; g_ack never high in slot 0.
- g_req write addr=12'h010, data=4'hA at slot 3, then read 12'h010 → write ack in slot 3. Read ack in slot 1. g_rvalid 2 cycles later with g_rdata=4'hA.
- g_req held continuously, alternating addresses → exactly 3 acks per 4-cycle period, with the VGA read unaffected.
- clr_start with clr_value=4'h5 → clr_busy high for the full clear duration. g_req pending gets no ack. Afterwards all 4096 cells read 4'h5 and the first g_ack follows clr_busy falling.
- RSTN low at clr_ptr≈2000 → clr_busy=0 next cycle. Cells below the pointer hold 4'h5, cells above keep their old content.
- clr_start with g_req in the same ack-able cycle → g_ack in that cycle; clr_busy rises next cycle.

Source files
------------

// File: rtl/map_ram_pkg.sv
// Shared constants, FSM state type and cell codes for the map RAM and the blocks around it.
package map_ram_pkg;

   localparam int ADDR_W    = 12;
   localparam int DATA_W    = 4;
   localparam int SLOT_N    = 4;
   localparam int MAP_DEPTH = 4096;
   localparam int VGA_SLOT  = 0;

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } arb_state_t;

   // Cell codes understood by both the game logic and the VGA renderer
   localparam logic [3:0] EMPTY      = 4'h0;
   localparam logic [3:0] SNAKE_BODY = 4'h1;
   localparam logic [3:0] SNAKE_HEAD = 4'h2;
   localparam logic [3:0] FOOD       = 4'h3;
   localparam logic [3:0] WALL       = 4'h4;

endpackage

// File: rtl/map_clear_engine.sv
// Address walker for the full-map clear: holds the fill code and steps through every cell once.
module map_clear_engine #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [DATA_W-1:0] start_value,
   input  logic              advance,
   output logic [ADDR_W-1:0] clr_ptr,
   output logic [DATA_W-1:0] fill_value,
   output logic              done
);

   logic last_cell;

   assign last_cell = &clr_ptr;
   assign done      = advance && last_cell;

   // The pointer returns to zero only through the terminal write, never by overflow
   always_ff @(posedge clk) begin
      if (!rstn) begin
         clr_ptr    <= '0;
         fill_value <= '0;
      end else if (start) begin
         clr_ptr    <= '0;
         fill_value <= start_value;
      end else if (advance) begin
         clr_ptr <= last_cell ? '0 : clr_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/map_ram_arbiter.sv
// Slot-wheel arbiter for the shared map RAM: slot 0 feeds VGA, the other slots serve the
// game port or, while clearing, the clear engine.
module map_ram_arbiter #(
   parameter int ADDR_W = map_ram_pkg::ADDR_W,
   parameter int DATA_W = map_ram_pkg::DATA_W,
   parameter int SLOT_N = map_ram_pkg::SLOT_N
) (
   input  logic              clk_100mhz,
   input  logic              RSTN,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic [DATA_W-1:0] vga_data,
   input  logic              g_req,
   input  logic              g_we,
   input  logic [ADDR_W-1:0] g_addr,
   input  logic [DATA_W-1:0] g_wdata,
   output logic              g_ack,
   output logic [DATA_W-1:0] g_rdata,
   output logic              g_rvalid,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_value,
   output logic              clr_busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   import map_ram_pkg::*;

   localparam int SLOT_W = (SLOT_N > 1) ? $clog2(SLOT_N) : 1;

   arb_state_t        state;
   logic [SLOT_W-1:0] slot;
   logic              is_vga;
   logic              clr_go;
   logic              clr_adv;
   logic              clr_done;
   logic [ADDR_W-1:0] clr_ptr;
   logic [DATA_W-1:0] fill_value;
   logic              vga_pend;
   logic              rd_pend;

   assign is_vga   = (slot == SLOT_W'(VGA_SLOT));
   assign clr_go   = (state == ST_IDLE) && clr_start;
   assign clr_busy = (state == ST_CLEAR);
   assign g_ack    = RSTN && !is_vga && (state == ST_IDLE) && g_req;
   assign clr_adv  = RSTN && !is_vga && (state == ST_CLEAR);

   always_ff @(posedge clk_100mhz) begin
      if (!RSTN) begin
         slot <= '0;
      end else if (slot == SLOT_W'(SLOT_N - 1)) begin
         slot <= '0;
      end else begin
         slot <= slot + 1'b1;
      end
   end

   // A clear request in an ack-able cycle still lets that ack through; the clear starts next cycle
   always_ff @(posedge clk_100mhz) begin
      if (!RSTN) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (clr_start) state <= ST_CLEAR;
            ST_CLEAR: if (clr_done)  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   map_clear_engine #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_clear (
      .clk         (clk_100mhz),
      .rstn        (RSTN),
      .start       (clr_go),
      .start_value (clr_value),
      .advance     (clr_adv),
      .clr_ptr     (clr_ptr),
      .fill_value  (fill_value),
      .done        (clr_done)
   );

   always_comb begin
      ram_addr  = g_addr;
      ram_we    = 1'b0;
      ram_wdata = g_wdata;
      if (is_vga) begin
         ram_addr = vga_addr;
      end else if (clr_adv) begin
         ram_addr  = clr_ptr;
         ram_we    = 1'b1;
         ram_wdata = fill_value;
      end else if (g_ack) begin
         ram_we = g_we;
      end
   end

   // The RAM answers one cycle after the address, so each requester gets a one-deep pending flag
   always_ff @(posedge clk_100mhz) begin
      if (!RSTN) begin
         vga_pend <= 1'b0;
         vga_data <= '0;
         rd_pend  <= 1'b0;
         g_rdata  <= '0;
         g_rvalid <= 1'b0;
      end else begin
         vga_pend <= is_vga;
         if (vga_pend) vga_data <= ram_rdata;
         rd_pend  <= g_ack && !g_we;
         if (rd_pend) g_rdata <= ram_rdata;
         g_rvalid <= rd_pend;
      end
   end

endmodule

// File: tb/tb_map_ram_arbiter.sv
// Directed bench for map_ram_arbiter with a behavioural synchronous 4096x4 RAM attached.
module tb_map_ram_arbiter;

   logic        clk_100mhz = 1'b0;
   logic        RSTN;
   logic [11:0] vga_addr;
   logic [3:0]  vga_data;
   logic        g_req;
   logic        g_we;
   logic [11:0] g_addr;
   logic [3:0]  g_wdata;
   logic        g_ack;
   logic [3:0]  g_rdata;
   logic        g_rvalid;
   logic        clr_start;
   logic [3:0]  clr_value;
   logic        clr_busy;
   logic [11:0] ram_addr;
   logic        ram_we;
   logic [3:0]  ram_wdata;
   logic [3:0]  ram_rdata;

   logic [3:0]  mem [4096];
   logic        do_preload = 1'b0;

   int total = 0;
   int bad = 0;
   int bslot = 0;
   int ack0_viol = 0;

   always #5 clk_100mhz = ~clk_100mhz;

   map_ram_arbiter dut (
      .clk_100mhz (clk_100mhz),
      .RSTN       (RSTN),
      .vga_addr   (vga_addr),
      .vga_data   (vga_data),
      .g_req      (g_req),
      .g_we       (g_we),
      .g_addr     (g_addr),
      .g_wdata    (g_wdata),
      .g_ack      (g_ack),
      .g_rdata    (g_rdata),
      .g_rvalid   (g_rvalid),
      .clr_start  (clr_start),
      .clr_value  (clr_value),
      .clr_busy   (clr_busy),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   // Preload puts addr[3:0] into every cell so reads have a predictable answer
   always @(posedge clk_100mhz) begin
      if (do_preload) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 4'(i);
      end else if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
      end
      ram_rdata <= mem[ram_addr];
   end

   always @(negedge clk_100mhz) begin
      if (RSTN === 1'b1 && bslot == 0 && g_ack === 1'b1) ack0_viol++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic we, input logic [11:0] addr,
                                input logic [3:0] wdata);
      g_req   = req;
      g_we    = we;
      g_addr  = addr;
      g_wdata = wdata;
      #1;
   endtask

   task automatic tick();
      @(posedge clk_100mhz);
      #1;
      bslot = (bslot + 1) % 4;
   endtask

   initial begin
      logic [3:0] exp_q[$];
      int acks;
      int busy_cycles;
      int ack_in_clear;
      int rv_in_clear;
      int guard;
      int nbad;
      int wcount;
      logic [3:0] exp_cell;

      RSTN      = 1'b0;
      vga_addr  = 12'h123;
      clr_start = 1'b0;
      clr_value = 4'h0;
      applyStimulus(1'b0, 1'b0, 12'h000, 4'h0);

      do_preload = 1'b1;
      tick();
      do_preload = 1'b0;
      applyStimulus(1'b1, 1'b1, 12'h055, 4'h9);
      checkOutput("rst_ack_forced", g_ack, 0);
      checkOutput("rst_we_forced", ram_we, 0);
      tick();
      bslot = 0;
      checkOutput("rst_vga_data", vga_data, 0);
      checkOutput("rst_g_rdata", g_rdata, 0);
      checkOutput("rst_g_rvalid", g_rvalid, 0);
      checkOutput("rst_clr_busy", clr_busy, 0);

      RSTN = 1'b1;
      applyStimulus(1'b0, 1'b0, 12'h000, 4'h0);
      checkOutput("vga_slot_addr", ram_addr, 12'h123);
      checkOutput("vga_slot_we", ram_we, 0);
      tick();
      tick();
      checkOutput("vga_data_first", vga_data, 4'h3);

      $display("[TB] game write then read");
      tick();
      applyStimulus(1'b1, 1'b1, 12'h010, 4'hA);
      checkOutput("wr_ack", g_ack, 1);
      checkOutput("wr_ram_we", ram_we, 1);
      checkOutput("wr_ram_addr", ram_addr, 12'h010);
      checkOutput("wr_ram_wdata", ram_wdata, 4'hA);
      tick();
      applyStimulus(1'b1, 1'b0, 12'h010, 4'h0);
      checkOutput("rd_slot0_noack", g_ack, 0);
      checkOutput("rd_slot0_vga_addr", ram_addr, 12'h123);
      tick();
      checkOutput("rd_ack_slot1", g_ack, 1);
      checkOutput("rd_ram_we", ram_we, 0);
      tick();
      applyStimulus(1'b0, 1'b0, 12'h000, 4'h0);
      checkOutput("rd_rvalid_early", g_rvalid, 0);
      tick();
      checkOutput("rd_rvalid", g_rvalid, 1);
      checkOutput("rd_rdata", g_rdata, 4'hA);
      tick();
      checkOutput("rd_rvalid_pulse", g_rvalid, 0);

      $display("[TB] continuous requests");
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(i < 8, 1'b0, i[0] ? 12'h0F7 : 12'h010, 4'h0);
         if (g_ack) begin
            acks++;
            exp_q.push_back(g_addr == 12'h010 ? 4'hA : 4'h7);
         end
         if (g_rvalid) begin
            if (exp_q.size() > 0) checkOutput("burst_rdata", g_rdata, exp_q.pop_front());
            else checkOutput("burst_rvalid_spurious", g_rvalid, 0);
         end
         tick();
      end
      checkOutput("burst_acks", acks, 6);
      checkOutput("burst_q_empty", exp_q.size(), 0);
      checkOutput("burst_vga", vga_data, 4'h3);

      $display("[TB] clear with concurrent request");
      clr_start = 1'b1;
      clr_value = 4'h5;
      applyStimulus(1'b1, 1'b0, 12'h0F7, 4'h0);
      checkOutput("clr_same_cycle_ack", g_ack, 1);
      checkOutput("clr_busy_before", clr_busy, 0);
      tick();
      clr_start = 1'b0;
      clr_value = 4'h0;
      applyStimulus(1'b1, 1'b0, 12'h020, 4'h0);
      checkOutput("clr_busy_rise", clr_busy, 1);
      checkOutput("clr_first_we", ram_we, 1);
      checkOutput("clr_first_addr", ram_addr, 12'h000);
      checkOutput("clr_first_wdata", ram_wdata, 4'h5);
      busy_cycles = 0;
      ack_in_clear = 0;
      rv_in_clear = 0;
      guard = 0;
      while (clr_busy && guard < 6000) begin
         busy_cycles++;
         if (g_ack) ack_in_clear++;
         if (g_rvalid) begin
            rv_in_clear++;
            checkOutput("clr_pre_rdata", g_rdata, 4'h7);
         end
         tick();
         guard++;
      end
      checkOutput("clr_duration", busy_cycles, 5461);
      checkOutput("clr_no_ack", ack_in_clear, 0);
      checkOutput("clr_pre_rvalid_cnt", rv_in_clear, 1);
      checkOutput("clr_done_busy", clr_busy, 0);
      checkOutput("post_clr_slot0_ack", g_ack, 0);
      tick();
      checkOutput("post_clr_ack", g_ack, 1);
      tick();
      applyStimulus(1'b0, 1'b0, 12'h000, 4'h0);
      tick();
      checkOutput("post_clr_rvalid", g_rvalid, 1);
      checkOutput("post_clr_rdata", g_rdata, 4'h5);
      nbad = 0;
      for (int i = 0; i < 4096; i++) if (mem[i] !== 4'h5) nbad++;
      checkOutput("clr_cells", nbad, 0);

      $display("[TB] reset during clear");
      do_preload = 1'b1;
      tick();
      do_preload = 1'b0;
      clr_start = 1'b1;
      clr_value = 4'h5;
      #1;
      tick();
      clr_start = 1'b0;
      clr_value = 4'h0;
      wcount = 0;
      for (int i = 0; i < 2667; i++) begin
         if (bslot != 0) wcount++;
         tick();
      end
      RSTN = 1'b0;
      applyStimulus(1'b1, 1'b1, 12'h200, 4'hF);
      checkOutput("midclr_rst_we", ram_we, 0);
      checkOutput("midclr_rst_ack", g_ack, 0);
      tick();
      bslot = 0;
      RSTN = 1'b1;
      applyStimulus(1'b0, 1'b0, 12'h000, 4'h0);
      checkOutput("midclr_busy_drop", clr_busy, 0);
      checkOutput("midclr_vga_reset", vga_data, 0);
      nbad = 0;
      for (int i = 0; i < 4096; i++) begin
         exp_cell = (i < wcount) ? 4'h5 : 4'(i);
         if (mem[i] !== exp_cell) nbad++;
      end
      checkOutput("midclr_cells", nbad, 0);

      $display("[TB] reset between read ack and rvalid");
      tick();
      applyStimulus(1'b1, 1'b0, 12'h033, 4'h0);
      checkOutput("cancel_ack", g_ack, 1);
      tick();
      applyStimulus(1'b0, 1'b0, 12'h000, 4'h0);
      RSTN = 1'b0;
      #1;
      tick();
      bslot = 0;
      RSTN = 1'b1;
      #1;
      checkOutput("cancel_rvalid", g_rvalid, 0);
      checkOutput("cancel_rdata", g_rdata, 0);
      tick();
      checkOutput("cancel_rvalid_late", g_rvalid, 0);

      checkOutput("ack_in_slot0", ack0_viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
